datapath_fetch: RTL and testbench
=================================

# datapath_fetch

Instruction-fetch stage of the 16-bit pipelined CPU. It owns the PC, issues reads to a 1-cycle-latency instruction memory, buffers returned words in a 2-entry queue, and presents `{instr, PC}` on `IF_ID` to the decode/register-read stage. It honours a downstream stall and a redirect (jump/branch/call) from later stages, discarding wrong-path fetches.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000, address of the first fetch after reset.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_addr`  out  16  imem read address; always equals internal `fetch_pc`.
- `i_rd`  out  1  imem read request; memory always accepts.
- `i_rddata`  in  16  read data, valid exactly one cycle after an `i_rd` cycle.
- `stall`  in  1  decode cannot accept `IF_ID` this cycle.
- `redirect`  in  1  control-flow change; overrides `stall`.
- `redirect_pc`  in  16  target PC, sampled when `redirect`=1.
- `IF_ID`  out  32  `{instr[31:16], PC[15:0]}` of queue head; 0 when `if_valid`=0.
- `if_valid`  out  1  queue non-empty.
- `perf_fetched`  out  16  instructions delivered to decode (see Configuration).

## Operation
- State: `fetch_pc` (16), `inflight` flag plus `inflight_pc` (16), 2-entry FIFO of `{instr, pc}` with `count` (0..2), `perf` counter.
- `pop` = `if_valid & ~stall & ~redirect`. Head leaves the queue on `pop`.
- Issue rule: `i_rd` = `~reset & ~redirect & (count + inflight - pop < 2)`. On issue: `inflight`<=1, `inflight_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc + 2` (16-bit wrap: 16'hFFFE -> 16'h0000). With no issue, `inflight`<=0.
- Response: if `inflight`=1 and no `redirect`, push `{i_rddata, inflight_pc}` at the tail. Simultaneous push and pop are allowed; `count` changes by push - pop. The issue rule guarantees no push when full; no assertion is needed beyond a sim-only overflow check.
- Redirect: in the same edge, clear the FIFO (`count`<=0), drop any response arriving this cycle, set `inflight`<=0 and `fetch_pc`<=`redirect_pc`. `i_rd`=0 in the redirect cycle. Back-to-back redirects: the last one wins.
- `stall` with `count`=0 has no effect. `stall` never blocks a push.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, `count`=0, `inflight`=0, `perf`=0. Hence `i_rd`=0, `if_valid`=0, `IF_ID`=0, `perf_fetched`=0, and `i_addr`=`RESET_PC` during reset.
- First cycle after reset (C0): `i_rd`=1 with `i_addr`=`RESET_PC`. Data returns in C1. `if_valid`=1 with `IF_ID`={word, `RESET_PC`} in C2.
- Steady state without stall: one issue and one delivery per cycle. PCs on `IF_ID` are consecutive, stepping by 2.
- Redirect in cycle R: issue of `redirect_pc` in R+1; `if_valid` with `PC`=`redirect_pc` in R+3. `if_valid`=0 in R+1 and R+2.
- Stall: `IF_ID` is held stable for every stalled cycle. The FIFO fills to 2 and issue stops within 2 cycles. On release, delivery resumes next cycle with no bubble.
- Reset asserted mid-operation clears all state in one edge. A response arriving during reset is ignored.

## Configuration
- `FETCH_PERF_EN` defined: `perf` increments by 1 on every `pop` and wraps at 16 bits. It is cleared by reset and by nothing else. `perf_fetched`=`perf`.
- Not defined: no counter is built and `perf_fetched` is tied to 16'h0000.

## Test plan
- Reset, no stall, imem returns `addr^16'hA5A5`: `IF_ID` shows PC 0,2,4,… from C2, with one instruction per cycle and data matching.
- Stall asserted for 5 cycles while `IF_ID.PC`=6: `IF_ID` is stable at PC 6, `i_rd` drops after ≤2 cycles, `count`=2. After release, PCs 6,8,10 appear on consecutive cycles.
- Redirect to 16'h0100 while a fetch is in flight: no PC other than 16'h0100 appears after the redirect, `if_valid` is low for 2 cycles, and 16'h0100 appears at R+3.
- Redirect while stall=1 and FIFO full: the FIFO is flushed, stall is ignored, and the next delivered PC = `redirect_pc`.
- `fetch_pc` 16'hFFFE then run: next PC is 16'h0000. Reset asserted for 1 cycle mid-stream: outputs return to reset values, and fetch restarts at `RESET_PC` in C2.
- With `FETCH_PERF_EN`: 10 delivered plus 3 stalled cycles gives `perf_fetched`=10. Without the macro it stays 0.

Source files
------------

// File: rtl/datapath_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : datapath_fetch                                                |
// | Purpose  : Instruction-fetch stage of the 16-bit pipelined CPU. Owns the |
// |            PC, issues reads to a 1-cycle-latency instruction memory,     |
// |            buffers returned words in a 2-entry queue and presents        |
// |            {instr, pc} to decode. Honours stall and redirect.            |
// | Options  : FETCH_PERF_EN - when defined, builds a 16-bit counter of      |
// |            instructions delivered to decode (perf_fetched).              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module datapath_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] i_addr,
   output logic        i_rd,
   input  logic [15:0] i_rddata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [31:0] IF_ID,
   output logic        if_valid,
   output logic [15:0] perf_fetched
);

   logic [15:0] fetch_pc;
   logic        inflight;
   logic [15:0] inflight_pc;
   logic [1:0]  count;
   logic [31:0] q0;          // queue head
   logic [31:0] q1;          // second entry
   logic        pop;
   logic        push;
   logic [2:0]  occ_after_pop;
   logic [31:0] new_entry;

   assign if_valid      = (count != 2'd0);
   assign pop           = if_valid & ~stall & ~redirect;
   // A redirect kills whatever response arrives in the same cycle.
   assign push          = inflight & ~redirect;
   // Queue slots already claimed (held + in flight) once this cycle's pop
   // leaves; a new read is only issued if its word is sure to have a slot.
   assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign i_rd          = ~reset & ~redirect & (occ_after_pop < 3'd2);
   assign i_addr        = fetch_pc;
   assign new_entry     = {i_rddata, inflight_pc};
   assign IF_ID         = if_valid ? q0 : 32'h0000_0000;

   // PC and in-flight request tracking; redirect overrides normal issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 16'h0000;
      end else if (redirect) begin
         fetch_pc    <= redirect_pc;
         inflight    <= 1'b0;
      end else begin
         inflight <= i_rd;
         if (i_rd) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 16'd2;
         end
      end
   end

   // Two-entry queue kept head-aligned: q0 is always the oldest entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
         q0    <= 32'h0000_0000;
         q1    <= 32'h0000_0000;
      end else if (redirect) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (count == 2'd2) begin
                  q0 <= q1;
                  q1 <= new_entry;
               end else begin
                  q0 <= new_entry;
               end
            end
            2'b10: begin
               if (count == 2'd0) begin
                  q0 <= new_entry;
               end else begin
                  q1 <= new_entry;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               q0    <= q1;
               count <= count - 2'd1;
            end
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   // Simulation guard: the issue rule must never let a push hit a full queue.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(push && !pop && (count == 2'd2)));
      end
   end
`endif

`ifdef FETCH_PERF_EN
   logic [15:0] perf;

   // Delivered-instruction counter, cleared only by reset, wraps at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf <= 16'h0000;
      end else if (pop) begin
         perf <= perf + 16'd1;
      end
   end

   assign perf_fetched = perf;
`else
   assign perf_fetched = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_datapath_fetch                                             |
// | Purpose  : Directed self-checking bench for datapath_fetch. Memory model |
// |            returns addr ^ 16'hA5A5 one cycle after each read.            |
// | Options  : FETCH_PERF_EN - expected perf_fetched follows the DUT build.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_datapath_fetch;

`ifdef FETCH_PERF_EN
   localparam int PERF_ON = 1;
`else
   localparam int PERF_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] i_addr;
   logic        i_rd;
   logic [15:0] i_rddata = 16'hDEAD;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [31:0] IF_ID;
   logic        if_valid;
   logic [15:0] perf_fetched;

   int checks = 0;
   int errors = 0;

   datapath_fetch #(.RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_addr       (i_addr),
      .i_rd         (i_rd),
      .i_rddata     (i_rddata),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .IF_ID        (IF_ID),
      .if_valid     (if_valid),
      .perf_fetched (perf_fetched)
   );

   always #5 clk = ~clk;

   // Instruction memory: 1-cycle latency, garbage when no read was issued.
   always @(posedge clk) begin
      i_rddata <= i_rd ? (i_addr ^ 16'hA5A5) : 16'hDEAD;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] perf_exp(input int n);
      return (PERF_ON != 0) ? 32'(n) : 32'h0;
   endfunction

   initial begin
      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      tick();
      tick();
      // Reset state
      check("rst_i_rd",     {31'b0, i_rd},      32'h0);
      check("rst_valid",    {31'b0, if_valid},  32'h0);
      check("rst_ifid",     IF_ID,              32'h0);
      check("rst_perf",     {16'h0, perf_fetched}, 32'h0);
      check("rst_addr",     {16'h0, i_addr},    32'h0);

      // C0
      reset = 1'b0;
      #1;
      check("c0_i_rd",      {31'b0, i_rd},      32'h1);
      check("c0_addr",      {16'h0, i_addr},    32'h0000);
      tick(); // C1
      check("c1_valid",     {31'b0, if_valid},  32'h0);
      check("c1_addr",      {16'h0, i_addr},    32'h0002);
      tick(); // C2
      check("c2_valid",     {31'b0, if_valid},  32'h1);
      check("c2_ifid",      IF_ID,              32'hA5A5_0000);
      tick(); // C3
      check("c3_ifid",      IF_ID,              32'hA5A7_0002);
      tick(); // C4
      check("c4_ifid",      IF_ID,              32'hA5A1_0004);
      tick(); // C5: head PC 6, stall for 5 cycles
      check("c5_ifid",      IF_ID,              32'hA5A3_0006);
      stall = 1'b1;
      #1;
      check("c5_stall_i_rd", {31'b0, i_rd},     32'h0);
      for (int k = 0; k < 4; k++) begin
         tick(); // C6..C9
         check("stall_ifid", IF_ID,             32'hA5A3_0006);
         check("stall_i_rd", {31'b0, i_rd},     32'h0);
         check("stall_cnt2", {30'b0, dut.count}, 32'h2);
      end
      tick(); // C10: release
      stall = 1'b0;
      #1;
      check("c10_ifid",     IF_ID,              32'hA5A3_0006);
      check("c10_i_rd",     {31'b0, i_rd},      32'h1);
      check("c10_addr",     {16'h0, i_addr},    32'h000A);
      tick(); // C11
      check("c11_ifid",     IF_ID,              32'hA5AD_0008);
      tick(); // C12
      check("c12_ifid",     IF_ID,              32'hA5AF_000A);
      tick(); // C13: redirect with fetch of 14 in flight
      check("c13_ifid",     IF_ID,              32'hA5A9_000C);
      check("c13_perf",     {16'h0, perf_fetched}, perf_exp(6));
      redirect    = 1'b1;
      redirect_pc = 16'h0100;
      #1;
      check("r_i_rd",       {31'b0, i_rd},      32'h0);
      tick(); // R+1
      redirect = 1'b0;
      #1;
      check("r1_valid",     {31'b0, if_valid},  32'h0);
      check("r1_i_rd",      {31'b0, i_rd},      32'h1);
      check("r1_addr",      {16'h0, i_addr},    32'h0100);
      tick(); // R+2
      check("r2_valid",     {31'b0, if_valid},  32'h0);
      tick(); // R+3
      check("r3_ifid",      IF_ID,              32'hA4A5_0100);
      tick(); // C17: stall until full
      check("c17_ifid",     IF_ID,              32'hA4A7_0102);
      check("c17_perf",     {16'h0, perf_fetched}, perf_exp(7));
      stall = 1'b1;
      tick(); // C18
      check("c18_ifid",     IF_ID,              32'hA4A7_0102);
      check("c18_i_rd",     {31'b0, i_rd},      32'h0);
      check("c18_cnt2",     {30'b0, dut.count}, 32'h2);
      tick(); // C19: redirect while stalled and full
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      #1;
      check("rf_i_rd",      {31'b0, i_rd},      32'h0);
      tick(); // R+1, stall still high with empty queue
      redirect = 1'b0;
      #1;
      check("rf1_valid",    {31'b0, if_valid},  32'h0);
      check("rf1_i_rd",     {31'b0, i_rd},      32'h1);
      check("rf1_addr",     {16'h0, i_addr},    32'hFFFE);
      tick(); // R+2
      stall = 1'b0;
      #1;
      check("rf2_valid",    {31'b0, if_valid},  32'h0);
      check("wrap_addr",    {16'h0, i_addr},    32'h0000);
      tick(); // R+3
      check("rf3_ifid",     IF_ID,              32'h5A5B_FFFE);
      tick(); // wrapped PC
      check("wrap_ifid",    IF_ID,              32'hA5A5_0000);
      check("wrap_perf",    {16'h0, perf_fetched}, perf_exp(8));
      tick(); // one-cycle reset mid-stream
      reset = 1'b1;
      #1;
      check("mrst_i_rd",    {31'b0, i_rd},      32'h0);
      tick(); // C0 after reset
      reset = 1'b0;
      #1;
      check("mrst_valid",   {31'b0, if_valid},  32'h0);
      check("mrst_ifid",    IF_ID,              32'h0);
      check("mrst_perf",    {16'h0, perf_fetched}, 32'h0);
      check("mrst_i_rd1",   {31'b0, i_rd},      32'h1);
      check("mrst_addr",    {16'h0, i_addr},    32'h0000);
      tick(); // C1
      check("mrst_c1",      {31'b0, if_valid},  32'h0);
      tick(); // C2
      check("mrst_c2_ifid", IF_ID,              32'hA5A5_0000);
      tick();
      check("mrst_c3_ifid", IF_ID,              32'hA5A7_0002);
      check("mrst_c3_perf", {16'h0, perf_fetched}, perf_exp(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
